lamp_serializer: RTL and testbench

- Downstream stage of bound_flash: consumes the 16-bit lamp vector and shifts it out to an external 74HC595-style shift-register LED driver chain.
- Uses a 3-wire serial bus: ser_data, ser_clk and ser_latch.
- Sends a frame whenever the lamp value differs from the last value sent, and always sends one frame after reset.
- Lets the lamp pattern drive physical LEDs over three pins instead of sixteen.

---
 rtl/bound_flash_pkg.sv | 14 +
 rtl/lamp_serializer_if.sv | 32 +++
 rtl/lamp_ser_tick.sv | 49 ++++
 rtl/lamp_serializer.sv | 163 ++++++++++++++++
 tb/tb_lamp_serializer.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bound_flash_pkg.sv
// Shared types and constants for the bound_flash lamp path and its
// serial LED driver back end (lamp_serializer).
package bound_flash_pkg;

  localparam int LAMP_W          = 16;
  localparam int CLK_DIV_DEFAULT = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LATCH = 2'd2
  } ser_state_t;

endpackage

// File: rtl/lamp_serializer_if.sv
// Lamp input plus 3-wire shift-register bus (data/clock/latch) and frame
// status. master = serializer side, slave = consumer/driver side.
interface lamp_serializer_if #(
  parameter int WIDTH = 16
);

  logic [WIDTH-1:0] lamp;
  logic             ser_data;
  logic             ser_clk;
  logic             ser_latch;
  logic             busy;
  logic             done;

  modport master (
    input  lamp,
    output ser_data,
    output ser_clk,
    output ser_latch,
    output busy,
    output done
  );

  modport slave (
    output lamp,
    input  ser_data,
    input  ser_clk,
    input  ser_latch,
    input  busy,
    input  done
  );

endinterface

// File: rtl/lamp_ser_tick.sv
// Half-period timer for lamp_serializer. Counts CLK_DIV cycles per ser_clk
// half-period while enabled, flags the last cycle of each half (phase_end)
// and tracks which half is current (half: 0 = low, 1 = high).
module lamp_ser_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic phase_end,
  output logic half
);

  localparam int            DW       = $clog2(CLK_DIV) + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          half_q, half_d;

  assign phase_end = en && (div_cnt_q == DIV_LAST);
  assign half      = half_q;

  // Next count/half: held at zero while disabled so every frame starts aligned.
  always_comb begin
    div_cnt_d = div_cnt_q;
    half_d    = half_q;
    if (!en) begin
      div_cnt_d = '0;
      half_d    = 1'b0;
    end else if (phase_end) begin
      div_cnt_d = '0;
      half_d    = ~half_q;
    end else begin
      div_cnt_d = div_cnt_q + DW'(1);
    end
  end

  // Timer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
      half_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      half_q    <= half_d;
    end
  end

endmodule

// File: rtl/lamp_serializer.sv
// lamp_serializer: shifts the lamp vector MSB first into a 74HC595-style
// LED driver chain whenever it differs from the last frame sent, plus one
// frame after every reset. All outputs are registered.
// Optional: define LAMP_SER_REFRESH_EN to resend the last value after
// REFRESH_CYCLES trigger-free idle cycles.
module lamp_serializer
  import bound_flash_pkg::*;
#(
  parameter int WIDTH          = LAMP_W,
  parameter int CLK_DIV        = CLK_DIV_DEFAULT,
  parameter int REFRESH_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  lamp_serializer_if.master   bus
);

  localparam int            BW       = $clog2(WIDTH);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] sent_q, sent_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             init_q, init_d;
  logic             ser_data_q, ser_data_d;
  logic             ser_clk_q, ser_clk_d;
  logic             ser_latch_q, ser_latch_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             phase_end, half;
  logic             trigger;

  lamp_ser_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk       (clk),
    .rst       (rst),
    .en        (state_q != S_IDLE),
    .phase_end (phase_end),
    .half      (half)
  );

`ifdef LAMP_SER_REFRESH_EN
  localparam int            RW      = $clog2(REFRESH_CYCLES) + 1;
  localparam logic [RW-1:0] RF_LAST = RW'(REFRESH_CYCLES - 1);

  logic [RW-1:0] refresh_cnt_q, refresh_cnt_d;
  logic          refresh_req_q, refresh_req_d;

  assign trigger = (bus.lamp != sent_q) || init_q || refresh_req_q;

  // Idle-time counter; a request is raised after the last counted cycle
  // and consumed as a trigger on the following idle cycle.
  always_comb begin
    refresh_cnt_d = refresh_cnt_q;
    refresh_req_d = 1'b0;
    if ((state_q != S_IDLE) || trigger) begin
      refresh_cnt_d = '0;
    end else if (refresh_cnt_q == RF_LAST) begin
      refresh_cnt_d = '0;
      refresh_req_d = 1'b1;
    end else begin
      refresh_cnt_d = refresh_cnt_q + RW'(1);
    end
  end

  // Refresh registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt_q <= '0;
      refresh_req_q <= 1'b0;
    end else begin
      refresh_cnt_q <= refresh_cnt_d;
      refresh_req_q <= refresh_req_d;
    end
  end
`else
  localparam int unused_refresh_cycles = REFRESH_CYCLES;

  assign trigger = (bus.lamp != sent_q) || init_q;
`endif

  // Frame FSM: load on trigger, shift one bit per low+high period, latch.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    sent_d     = sent_q;
    bit_cnt_d  = bit_cnt_q;
    init_d     = init_q;
    ser_data_d = ser_data_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          shift_d    = bus.lamp;
          sent_d     = bus.lamp;
          init_d     = 1'b0;
          bit_cnt_d  = BIT_LAST;
          ser_data_d = bus.lamp[WIDTH-1];
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // Data only moves as ser_clk falls, so it is stable around each rise.
        if (phase_end && half) begin
          shift_d = {shift_q[WIDTH-2:0], 1'b0};
          if (bit_cnt_q == '0) begin
            ser_data_d = 1'b0;
            state_d    = S_LATCH;
          end else begin
            bit_cnt_d  = bit_cnt_q - BW'(1);
            ser_data_d = shift_q[WIDTH-2];
          end
        end
      end
      S_LATCH: begin
        if (phase_end) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    ser_clk_d   = (state_d == S_SHIFT) ? (phase_end ? ~ser_clk_q : ser_clk_q) : 1'b0;
    ser_latch_d = (state_d == S_LATCH);
    busy_d      = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any frame without a latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      sent_q      <= '0;
      bit_cnt_q   <= '0;
      init_q      <= 1'b1;
      ser_data_q  <= 1'b0;
      ser_clk_q   <= 1'b0;
      ser_latch_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      sent_q      <= sent_d;
      bit_cnt_q   <= bit_cnt_d;
      init_q      <= init_d;
      ser_data_q  <= ser_data_d;
      ser_clk_q   <= ser_clk_d;
      ser_latch_q <= ser_latch_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.ser_data  = ser_data_q;
  assign bus.ser_clk   = ser_clk_q;
  assign bus.ser_latch = ser_latch_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_lamp_serializer.sv
// Directed bench for lamp_serializer (WIDTH=16, CLK_DIV=4, REFRESH_CYCLES=64).
// A receiver model on the falling clk edge shifts ser_data in on every
// ser_clk rise and records one frame per ser_latch pulse.
module tb_lamp_serializer;

  typedef struct {
    logic [15:0] word;
    int          nbits;
    int          latch_len;
  } frame_t;

  typedef struct {
    logic [15:0] lamp;
    logic [15:0] exp_word;
    int          exp_frames;
  } vec_t;

  logic clk;
  logic rst;

  lamp_serializer_if #(.WIDTH(16)) bus ();

  lamp_serializer #(
    .WIDTH          (16),
    .CLK_DIV        (4),
    .REFRESH_CYCLES (64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  int          cyc          = 0;
  frame_t      frames[$];
  logic [15:0] cur_word     = '0;
  int          cur_nbits    = 0;
  int          latch_len    = 0;
  int          latch_pulses = 0;
  int          proto_err    = 0;
  int          done_cnt     = 0;
  int          done_cyc     = 0;
  int          starts       = 0;
  int          start_cyc    = 0;
  logic        prev_clk     = 1'b0;
  logic        prev_data    = 1'b0;
  logic        prev_latch   = 1'b0;
  logic        prev_busy    = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Receiver model of the driver chain.
  always @(negedge clk) begin
    if (rst) begin
      cur_word  = '0;
      cur_nbits = 0;
      latch_len = 0;
    end else begin
      if (bus.ser_clk && !prev_clk) begin
        cur_word  = {cur_word[14:0], bus.ser_data};
        cur_nbits = cur_nbits + 1;
      end
      if (bus.ser_clk && (bus.ser_data !== prev_data)) proto_err = proto_err + 1;
      if (bus.ser_latch && bus.ser_clk) proto_err = proto_err + 1;
      if (bus.ser_latch) latch_len = latch_len + 1;
      if (!bus.ser_latch && prev_latch) begin
        frames.push_back('{cur_word, cur_nbits, latch_len});
        latch_pulses = latch_pulses + 1;
        cur_word     = '0;
        cur_nbits    = 0;
        latch_len    = 0;
      end
      if (bus.done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
      if (bus.busy && !prev_busy) begin
        starts    = starts + 1;
        start_cyc = cyc;
      end
    end
    prev_clk   = bus.ser_clk;
    prev_data  = bus.ser_data;
    prev_latch = bus.ser_latch;
    prev_busy  = bus.busy;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int d0;
    d0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (done_cnt != d0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_start(input int budget, output bit ok);
    int s0;
    s0 = starts;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (starts != s0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  vec_t vecs[6];
  int   st, b, s0, lp0, rel;
  bit   ok;

  initial begin
    vecs[0] = '{16'hA5C3, 16'b1010_0101_1100_0011, 1};
    vecs[1] = '{16'hA5C3, 16'h0000,                0};
    vecs[2] = '{16'h8000, 16'b1000_0000_0000_0000, 1};
    vecs[3] = '{16'h0001, 16'b0000_0000_0000_0001, 1};
    vecs[4] = '{16'hFFFF, 16'b1111_1111_1111_1111, 1};
    vecs[5] = '{16'h5A5A, 16'b0101_1010_0101_1010, 1};

    // Reset state.
    rst      = 1'b1;
    bus.lamp = 16'h0000;
    tick(3);
    check("rst_ser_data",  32'(bus.ser_data),  32'd0);
    check("rst_ser_clk",   32'(bus.ser_clk),   32'd0);
    check("rst_ser_latch", 32'(bus.ser_latch), 32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_done",      32'(bus.done),      32'd0);

    // Frame forced by init after reset release, lamp = 0.
    b   = frames.size();
    s0  = starts;
    rst = 1'b0;
    rel = cyc;
    wait_done(300, ok);
    check("init_done_seen", 32'(ok), 32'd1);
    check("init_done_latency", 32'(done_cyc - rel), 32'd133);
    check("init_frames", 32'(frames.size() - b), 32'd1);
    if (frames.size() > b) begin
      check("init_word",  32'(frames[b].word),      32'h0000);
      check("init_nbits", 32'(frames[b].nbits),     32'd16);
      check("init_latch", 32'(frames[b].latch_len), 32'd4);
    end

`ifdef LAMP_SER_REFRESH_EN
    // Constant lamp: forced resend every 133 + 64 cycles.
    begin
      int s1, s2;
      s1 = start_cyc;
      wait_start(400, ok);
      check("refresh_start1_seen", 32'(ok), 32'd1);
      s2 = start_cyc;
      check("refresh_period1", 32'(s2 - s1), 32'd197);
      wait_start(400, ok);
      check("refresh_start2_seen", 32'(ok), 32'd1);
      check("refresh_period2", 32'(start_cyc - s2), 32'd197);
      if (frames.size() > b + 1) check("refresh_word", 32'(frames[b+1].word), 32'h0000);
      else check("refresh_frame_count", 32'(frames.size() - b), 32'd2);
    end
`else
    tick(300);
    check("init_single_frame", 32'(starts - s0), 32'd1);

    // Single-frame vectors.
    for (int i = 0; i < 6; i++) begin
      st       = cyc;
      b        = frames.size();
      s0       = starts;
      bus.lamp = vecs[i].lamp;
      if (vecs[i].exp_frames == 1) begin
        wait_done(200, ok);
        check($sformatf("v%0d_done_seen", i), 32'(ok), 32'd1);
      end
      tick(150);
      check($sformatf("v%0d_starts", i), 32'(starts - s0), 32'(vecs[i].exp_frames));
      check($sformatf("v%0d_frames", i), 32'(frames.size() - b), 32'(vecs[i].exp_frames));
      check($sformatf("v%0d_busy_idle", i), 32'(bus.busy), 32'd0);
      if ((vecs[i].exp_frames == 1) && (frames.size() > b)) begin
        check($sformatf("v%0d_word", i),    32'(frames[b].word),      32'(vecs[i].exp_word));
        check($sformatf("v%0d_nbits", i),   32'(frames[b].nbits),     32'd16);
        check($sformatf("v%0d_latch", i),   32'(frames[b].latch_len), 32'd4);
        check($sformatf("v%0d_busy_at", i), 32'(start_cyc - st),      32'd1);
        check($sformatf("v%0d_latency", i), 32'(done_cyc - st),       32'd133);
      end
    end

    // Lamp steps during a frame: current frame, then one frame of the final value.
    st       = cyc;
    b        = frames.size();
    s0       = starts;
    bus.lamp = 16'h0001;
    tick(20);
    bus.lamp = 16'h0003;
    tick(20);
    bus.lamp = 16'h0007;
    wait_done(200, ok);
    check("step_done1_seen", 32'(ok), 32'd1);
    wait_done(200, ok);
    check("step_done2_seen", 32'(ok), 32'd1);
    check("step_back_to_back", 32'(done_cyc - st), 32'd266);
    tick(150);
    check("step_starts", 32'(starts - s0), 32'd2);
    if (frames.size() >= b + 2) begin
      check("step_word1", 32'(frames[b].word),   32'h0001);
      check("step_word2", 32'(frames[b+1].word), 32'h0007);
    end else begin
      check("step_frames", 32'(frames.size() - b), 32'd2);
    end

    // Lamp leaves and returns to the value being sent: no extra frame.
    b        = frames.size();
    s0       = starts;
    bus.lamp = 16'h00FF;
    tick(10);
    bus.lamp = 16'h1234;
    tick(20);
    bus.lamp = 16'h00FF;
    wait_done(200, ok);
    check("ret_done_seen", 32'(ok), 32'd1);
    tick(150);
    check("ret_starts", 32'(starts - s0), 32'd1);
    check("ret_busy", 32'(bus.busy), 32'd0);
    if (frames.size() > b) check("ret_word", 32'(frames[b].word), 32'h00FF);
    else check("ret_frames", 32'(frames.size() - b), 32'd1);

    // Reset during bit 7 of a frame.
    b        = frames.size();
    lp0      = latch_pulses;
    bus.lamp = 16'hC3A5;
    tick(60);
    check("mid_busy_before_rst", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_outputs", 32'({bus.ser_data, bus.ser_clk, bus.ser_latch, bus.busy, bus.done}), 32'd0);
    tick(3);
    check("mid_no_latch", 32'(latch_pulses - lp0), 32'd0);
    rst = 1'b0;
    rel = cyc;
    wait_done(300, ok);
    check("mid_done_seen", 32'(ok), 32'd1);
    check("mid_latency", 32'(done_cyc - rel), 32'd133);
    tick(20);
    check("mid_frames", 32'(frames.size() - b), 32'd1);
    if (frames.size() > b) begin
      check("mid_word",  32'(frames[b].word),  32'hC3A5);
      check("mid_nbits", 32'(frames[b].nbits), 32'd16);
    end
`endif

    check("protocol_errors", 32'(proto_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
